// File: rtl/gpcfg_arb.sv
// gpcfg_arb: two-master round-robin arbiter in front of a config register bank.
// One command is in flight at a time; writes hold the strobe for PULSE_LEN cycles.
module gpcfg_arb #(
   parameter int unsigned PULSE_LEN = 1,
   parameter logic [15:0] CFG_BASE  = 16'h0
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_be,
   output logic        m0_gnt,
   output logic        m0_done,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_be,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic [31:0] m1_rdata,
   output logic        cfg_wr_en,
   output logic        cfg_rd_en,
   output logic [3:0]  cfg_byte_en,
   output logic [31:0] cfg_wr_addr,
   output logic [31:0] cfg_rd_addr,
   output logic [31:0] cfg_wdata,
   input  logic [31:0] cfg_rdata,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      GNT,
      WR,
      RD,
      DONE
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(PULSE_LEN - 1);

   state_t      state_q;
   state_t      state_d;
   logic        owner_q;
   logic        last_q;
   logic        wr_q;
   logic [15:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [7:0]  cnt_q;
   logic [31:0] rdata_q;
   logic        any_req;
   logic        win;
   logic [15:0] addr_sum;
   logic [31:0] cfg_addr;
   logic        unused_addr;

   assign any_req     = m0_req | m1_req;
   assign win         = (m0_req & m1_req) ? ~last_q : m1_req;
   assign addr_sum    = CFG_BASE + addr_q;
   assign cfg_addr    = {16'h0, addr_sum};
   assign unused_addr = ^{m0_addr[31:16], m1_addr[31:16]};

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // last_q = 1 after reset so master 0 takes the first tie
   always_ff @(posedge hclk) begin
      if (hreset) begin
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         wr_q    <= 1'b0;
         addr_q  <= 16'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         cnt_q   <= 8'h0;
         rdata_q <= 32'h0;
      end else begin
         if (state_q == IDLE && any_req) begin
            owner_q <= win;
            last_q  <= win;
            wr_q    <= win ? m1_wr : m0_wr;
            addr_q  <= win ? m1_addr[15:0] : m0_addr[15:0];
            wdata_q <= win ? m1_wdata : m0_wdata;
            be_q    <= win ? m1_be : m0_be;
         end
         cnt_q <= (state_q == WR) ? cnt_q + 8'd1 : 8'd0;
         if (state_q == RD) begin
            rdata_q <= cfg_rdata;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      m0_gnt      = 1'b0;
      m1_gnt      = 1'b0;
      m0_done     = 1'b0;
      m1_done     = 1'b0;
      m0_rdata    = 32'h0;
      m1_rdata    = 32'h0;
      cfg_wr_en   = 1'b0;
      cfg_rd_en   = 1'b0;
      cfg_byte_en = 4'h0;
      cfg_wr_addr = 32'h0;
      cfg_rd_addr = 32'h0;
      cfg_wdata   = 32'h0;
      busy        = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = GNT;
            end
         end
         GNT: begin
            m0_gnt  = ~owner_q;
            m1_gnt  = owner_q;
            state_d = wr_q ? WR : RD;
         end
         WR: begin
            cfg_wr_en   = 1'b1;
            cfg_byte_en = be_q;
            cfg_wr_addr = cfg_addr;
            cfg_wdata   = wdata_q;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         RD: begin
            cfg_rd_en   = 1'b1;
            cfg_rd_addr = cfg_addr;
            state_d     = DONE;
         end
         DONE: begin
            m0_done  = ~owner_q;
            m1_done  = owner_q;
            m0_rdata = (~owner_q & ~wr_q) ? rdata_q : 32'h0;
            m1_rdata = (owner_q & ~wr_q) ? rdata_q : 32'h0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // outputs are forced quiet for the whole reset cycle
      if (hreset) begin
         m0_gnt      = 1'b0;
         m1_gnt      = 1'b0;
         m0_done     = 1'b0;
         m1_done     = 1'b0;
         m0_rdata    = 32'h0;
         m1_rdata    = 32'h0;
         cfg_wr_en   = 1'b0;
         cfg_rd_en   = 1'b0;
         cfg_byte_en = 4'h0;
         cfg_wr_addr = 32'h0;
         cfg_rd_addr = 32'h0;
         cfg_wdata   = 32'h0;
         busy        = 1'b0;
      end
   end

endmodule

// File: tb/tb_gpcfg_arb.sv
// tb_gpcfg_arb: directed scenarios plus a randomized run checked against
// a transaction-schedule model, on two parameterizations of gpcfg_arb.
module tb_gpcfg_arb;

   localparam int RN = 300;
   localparam int RM = RN + 16;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] cfg_rdata;

   logic        a_m0_gnt, a_m0_done, a_m1_gnt, a_m1_done;
   logic [31:0] a_m0_rdata, a_m1_rdata;
   logic        a_cfg_wr_en, a_cfg_rd_en, a_busy;
   logic [3:0]  a_cfg_byte_en;
   logic [31:0] a_cfg_wr_addr, a_cfg_rd_addr, a_cfg_wdata;

   logic        b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done;
   logic [31:0] b_m0_rdata, b_m1_rdata;
   logic        b_cfg_wr_en, b_cfg_rd_en, b_busy;
   logic [3:0]  b_cfg_byte_en;
   logic [31:0] b_cfg_wr_addr, b_cfg_rd_addr, b_cfg_wdata;

   logic [170:0] a_outs, b_outs;

   int checks = 0;
   int errors = 0;

   always #5 hclk = ~hclk;

   assign a_outs = {a_m0_gnt, a_m0_done, a_m0_rdata, a_m1_gnt, a_m1_done,
                    a_m1_rdata, a_cfg_wr_en, a_cfg_rd_en, a_cfg_byte_en,
                    a_cfg_wr_addr, a_cfg_rd_addr, a_cfg_wdata, a_busy};
   assign b_outs = {b_m0_gnt, b_m0_done, b_m0_rdata, b_m1_gnt, b_m1_done,
                    b_m1_rdata, b_cfg_wr_en, b_cfg_rd_en, b_cfg_byte_en,
                    b_cfg_wr_addr, b_cfg_rd_addr, b_cfg_wdata, b_busy};

   gpcfg_arb #(.PULSE_LEN(3), .CFG_BASE(16'h0000)) dut_a (
      .hclk(hclk), .hreset(hreset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
      .cfg_wr_en(a_cfg_wr_en), .cfg_rd_en(a_cfg_rd_en),
      .cfg_byte_en(a_cfg_byte_en), .cfg_wr_addr(a_cfg_wr_addr),
      .cfg_rd_addr(a_cfg_rd_addr), .cfg_wdata(a_cfg_wdata),
      .cfg_rdata(cfg_rdata), .busy(a_busy)
   );

   gpcfg_arb #(.PULSE_LEN(4), .CFG_BASE(16'h0002)) dut_b (
      .hclk(hclk), .hreset(hreset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
      .cfg_wr_en(b_cfg_wr_en), .cfg_rd_en(b_cfg_rd_en),
      .cfg_byte_en(b_cfg_byte_en), .cfg_wr_addr(b_cfg_wr_addr),
      .cfg_rd_addr(b_cfg_rd_addr), .cfg_wdata(b_cfg_wdata),
      .cfg_rdata(cfg_rdata), .busy(b_busy)
   );

   task automatic do_reset;
      hreset = 1'b1;
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (2) @(posedge hclk);
      #1;
      hreset = 1'b0;
   endtask

   task automatic test_reset;
      hreset = 1'b1;
      m0_req = 1'b1;
      m1_req = 1'b1;
      m0_wr  = 1'b1;
      m1_wr  = 1'b1;
      repeat (3) begin
         @(posedge hclk);
         #1;
         checks++;
         if (a_outs !== '0) begin
            errors++;
            $display("FAIL reset_a got %h want 0", a_outs);
         end
         checks++;
         if (b_outs !== '0) begin
            errors++;
            $display("FAIL reset_b got %h want 0", b_outs);
         end
      end
      @(posedge hclk);
      #1;
      hreset = 1'b0;
      #1;
      checks++;
      if (a_outs !== '0) begin
         errors++;
         $display("FAIL reset_after got %h want 0", a_outs);
      end
      @(posedge hclk);
      #1;
      checks++;
      if ({a_m0_gnt, a_m1_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL reset_tie got %b want 10", {a_m0_gnt, a_m1_gnt});
      end
      do_reset();
   endtask

   task automatic test_single_write;
      do_reset();
      m0_req    = 1'b1;
      m0_wr     = 1'b1;
      m0_addr   = 32'h0000_0004;
      m0_wdata  = 32'hA5A5_1234;
      m0_be     = 4'hF;
      cfg_rdata = 32'h0;
      for (int cy = 0; cy <= 7; cy++) begin
         if (cy > 0) begin
            @(posedge hclk);
            #1;
         end
         checks++;
         if (a_m0_gnt !== (cy == 1)) begin
            errors++;
            $display("FAIL wr_gnt cy%0d got %b", cy, a_m0_gnt);
         end
         checks++;
         if (a_cfg_wr_en !== (cy >= 2 && cy <= 4)) begin
            errors++;
            $display("FAIL wr_en cy%0d got %b", cy, a_cfg_wr_en);
         end
         if (cy >= 2 && cy <= 4) begin
            checks++;
            if ({a_cfg_wr_addr, a_cfg_wdata, a_cfg_byte_en} !==
                {32'h0000_0004, 32'hA5A5_1234, 4'hF}) begin
               errors++;
               $display("FAIL wr_cmd cy%0d got %h %h %h want 4 a5a51234 f",
                        cy, a_cfg_wr_addr, a_cfg_wdata, a_cfg_byte_en);
            end
         end
         checks++;
         if (a_m0_done !== (cy == 5)) begin
            errors++;
            $display("FAIL wr_done cy%0d got %b", cy, a_m0_done);
         end
         checks++;
         if (a_busy !== (cy >= 1 && cy <= 5)) begin
            errors++;
            $display("FAIL wr_busy cy%0d got %b", cy, a_busy);
         end
         if (cy == 1) m0_req = 1'b0;
      end
   endtask

   task automatic test_single_read;
      do_reset();
      m1_req    = 1'b1;
      m1_wr     = 1'b0;
      m1_addr   = 32'h0000_0008;
      m1_be     = 4'hF;
      cfg_rdata = 32'hDEAD_BEEF;
      for (int cy = 0; cy <= 6; cy++) begin
         if (cy > 0) begin
            @(posedge hclk);
            #1;
         end
         checks++;
         if (a_m1_gnt !== (cy == 1)) begin
            errors++;
            $display("FAIL rd_gnt cy%0d got %b", cy, a_m1_gnt);
         end
         checks++;
         if (a_cfg_rd_en !== (cy == 2)) begin
            errors++;
            $display("FAIL rd_en cy%0d got %b", cy, a_cfg_rd_en);
         end
         if (cy == 2) begin
            checks++;
            if ({a_cfg_rd_addr, a_cfg_byte_en} !== {32'h8, 4'h0}) begin
               errors++;
               $display("FAIL rd_addr got %h be %h want 8 0",
                        a_cfg_rd_addr, a_cfg_byte_en);
            end
         end
         checks++;
         if (a_m1_done !== (cy == 3)) begin
            errors++;
            $display("FAIL rd_done cy%0d got %b", cy, a_m1_done);
         end
         checks++;
         if (a_m1_rdata !== ((cy == 3) ? 32'hDEAD_BEEF : 32'h0)) begin
            errors++;
            $display("FAIL rd_data cy%0d got %h", cy, a_m1_rdata);
         end
         if (cy == 1) m1_req = 1'b0;
      end
   endtask

   task automatic test_tie;
      do_reset();
      m0_req  = 1'b1;
      m1_req  = 1'b1;
      m0_wr   = 1'b0;
      m1_wr   = 1'b0;
      m0_addr = 32'h10;
      m1_addr = 32'h20;
      for (int cy = 0; cy <= 10; cy++) begin
         if (cy > 0) begin
            @(posedge hclk);
            #1;
         end
         checks++;
         if ({a_m0_gnt, a_m1_gnt} !==
             {(cy == 1 || cy == 9), (cy == 5)}) begin
            errors++;
            $display("FAIL tie_gnt cy%0d got %b%b", cy, a_m0_gnt, a_m1_gnt);
         end
         checks++;
         if ({a_m0_done, a_m1_done} !== {(cy == 3), (cy == 7)}) begin
            errors++;
            $display("FAIL tie_done cy%0d got %b%b",
                     cy, a_m0_done, a_m1_done);
         end
         if (cy == 1) m0_req = 1'b0;
         if (cy == 5) m1_req = 1'b0;
         if (cy == 8) begin
            m0_req = 1'b1;
            m1_req = 1'b1;
         end
         if (cy == 9) m0_req = 1'b0;
      end
      m1_req = 1'b0;
   endtask

   task automatic test_partial_write;
      do_reset();
      m0_req   = 1'b1;
      m0_wr    = 1'b1;
      m0_addr  = 32'h1234_FFFF;
      m0_wdata = 32'h0BAD_F00D;
      m0_be    = 4'h2;
      for (int cy = 0; cy <= 8; cy++) begin
         if (cy > 0) begin
            @(posedge hclk);
            #1;
         end
         checks++;
         if (b_cfg_wr_en !== (cy >= 2 && cy <= 5)) begin
            errors++;
            $display("FAIL pw_en cy%0d got %b", cy, b_cfg_wr_en);
         end
         if (cy >= 2 && cy <= 5) begin
            checks++;
            if ({b_cfg_wr_addr, b_cfg_byte_en, b_cfg_wdata} !==
                {32'h0000_0001, 4'h2, 32'h0BAD_F00D}) begin
               errors++;
               $display("FAIL pw_cmd cy%0d got %h %h %h want 1 2 0badf00d",
                        cy, b_cfg_wr_addr, b_cfg_byte_en, b_cfg_wdata);
            end
         end
         if (cy == 2) begin
            checks++;
            if (a_cfg_wr_addr !== 32'h0000_FFFF) begin
               errors++;
               $display("FAIL pw_hi got %h want 0000ffff", a_cfg_wr_addr);
            end
         end
         checks++;
         if (b_m0_done !== (cy == 6)) begin
            errors++;
            $display("FAIL pw_done cy%0d got %b", cy, b_m0_done);
         end
         if (cy >= 1) begin
            m0_req   = 1'b0;
            m0_wdata = $urandom;
            m0_addr  = $urandom;
            m0_be    = 4'($urandom);
         end
      end
   endtask

   task automatic test_reset_mid_write;
      do_reset();
      m0_req   = 1'b1;
      m0_wr    = 1'b1;
      m0_addr  = 32'h10;
      m0_wdata = 32'h1111_2222;
      m0_be    = 4'hF;
      for (int cy = 1; cy <= 12; cy++) begin
         @(posedge hclk);
         #1;
         if (cy == 1) m0_req = 1'b0;
         if (cy == 2) begin
            checks++;
            if (b_cfg_wr_en !== 1'b1) begin
               errors++;
               $display("FAIL rmw_pre got %b want 1", b_cfg_wr_en);
            end
         end
         if (cy == 3) begin
            hreset = 1'b1;
            #1;
            checks++;
            if (b_outs !== '0) begin
               errors++;
               $display("FAIL rmw_during got %h want 0", b_outs);
            end
         end
         if (cy == 4) begin
            hreset = 1'b0;
            #1;
            checks++;
            if (b_outs !== '0) begin
               errors++;
               $display("FAIL rmw_after got %h want 0", b_outs);
            end
         end
         if (cy >= 5 && cy <= 10) begin
            checks++;
            if ({b_m0_done, b_busy, b_cfg_wr_en} !== 3'b000) begin
               errors++;
               $display("FAIL rmw_quiet cy%0d got %b%b%b",
                        cy, b_m0_done, b_busy, b_cfg_wr_en);
            end
         end
         if (cy == 10) begin
            m0_req = 1'b1;
            m1_req = 1'b1;
            m0_wr  = 1'b0;
            m1_wr  = 1'b0;
         end
         if (cy == 11) begin
            checks++;
            if ({b_m0_gnt, b_m1_gnt} !== 2'b10) begin
               errors++;
               $display("FAIL rmw_tie got %b%b want 10", b_m0_gnt, b_m1_gnt);
            end
            m0_req = 1'b0;
         end
      end
      m1_req = 1'b0;
   endtask

   // Model: a transaction decided in IDLE cycle t is granted at t+1,
   // strobes for len cycles from t+2, done at t+2+len, idle again at t+3+len.
   task automatic test_random(input bit sel);
      bit          g0[RM], g1[RM], d0[RM], d1[RM];
      bit          we[RM], re[RM], bz[RM];
      logic [31:0] r0[RM], r1[RM], wa[RM], ra[RM], wd[RM], src[RM];
      logic [3:0]  be[RM];
      bit          pend[2];
      bit          cw[2];
      logic [31:0] ca[2], cd[2];
      logic [3:0]  cb[2];
      int          next_idle, plen, len, t;
      bit          last, w;
      logic [15:0] base, sum;
      logic        o_g0, o_g1, o_d0, o_d1, o_we, o_re, o_bz;
      logic [31:0] o_r0, o_r1, o_wa, o_ra, o_wd;
      logic [3:0]  o_be;
      plen = sel ? 4 : 3;
      base = sel ? 16'h0002 : 16'h0000;
      for (int i = 0; i < RM; i++) begin
         g0[i] = 0; g1[i] = 0; d0[i] = 0; d1[i] = 0;
         we[i] = 0; re[i] = 0; bz[i] = 0;
         r0[i] = 0; r1[i] = 0; wa[i] = 0; ra[i] = 0; wd[i] = 0;
         be[i] = 0;
         src[i] = $urandom;
      end
      pend[0] = 0;
      pend[1] = 0;
      next_idle = 0;
      last = 1'b1;
      do_reset();
      for (int c = 0; c < RN; c++) begin
         if (c > 0) begin
            @(posedge hclk);
            #1;
         end
         o_g0 = sel ? b_m0_gnt : a_m0_gnt;
         o_g1 = sel ? b_m1_gnt : a_m1_gnt;
         o_d0 = sel ? b_m0_done : a_m0_done;
         o_d1 = sel ? b_m1_done : a_m1_done;
         o_r0 = sel ? b_m0_rdata : a_m0_rdata;
         o_r1 = sel ? b_m1_rdata : a_m1_rdata;
         o_we = sel ? b_cfg_wr_en : a_cfg_wr_en;
         o_re = sel ? b_cfg_rd_en : a_cfg_rd_en;
         o_be = sel ? b_cfg_byte_en : a_cfg_byte_en;
         o_wa = sel ? b_cfg_wr_addr : a_cfg_wr_addr;
         o_ra = sel ? b_cfg_rd_addr : a_cfg_rd_addr;
         o_wd = sel ? b_cfg_wdata : a_cfg_wdata;
         o_bz = sel ? b_busy : a_busy;
         checks++;
         if ({o_g0, o_g1, o_d0, o_d1} !== {g0[c], g1[c], d0[c], d1[c]}) begin
            errors++;
            $display("FAIL rnd%0d_hs cy%0d got %b%b%b%b want %b%b%b%b",
                     sel, c, o_g0, o_g1, o_d0, o_d1, g0[c], g1[c], d0[c], d1[c]);
         end
         checks++;
         if ({o_r0, o_r1} !== {r0[c], r1[c]}) begin
            errors++;
            $display("FAIL rnd%0d_rdata cy%0d got %h %h want %h %h",
                     sel, c, o_r0, o_r1, r0[c], r1[c]);
         end
         checks++;
         if ({o_we, o_re, o_bz, o_be} !== {we[c], re[c], bz[c], be[c]}) begin
            errors++;
            $display("FAIL rnd%0d_ctl cy%0d got %b%b%b %h want %b%b%b %h",
                     sel, c, o_we, o_re, o_bz, o_be, we[c], re[c], bz[c], be[c]);
         end
         checks++;
         if ({o_wa, o_ra, o_wd} !== {wa[c], ra[c], wd[c]}) begin
            errors++;
            $display("FAIL rnd%0d_bus cy%0d got %h %h %h want %h %h %h",
                     sel, c, o_wa, o_ra, o_wd, wa[c], ra[c], wd[c]);
         end
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && c < RN - 40 && $urandom_range(0, 2) == 0) begin
               pend[m] = 1'b1;
               cw[m]   = 1'($urandom_range(0, 1));
               ca[m]   = $urandom;
               cd[m]   = $urandom;
               cb[m]   = 4'($urandom);
            end
         end
         m0_req    = pend[0];
         m0_wr     = pend[0] ? cw[0] : 1'($urandom);
         m0_addr   = pend[0] ? ca[0] : $urandom;
         m0_wdata  = pend[0] ? cd[0] : $urandom;
         m0_be     = pend[0] ? cb[0] : 4'($urandom);
         m1_req    = pend[1];
         m1_wr     = pend[1] ? cw[1] : 1'($urandom);
         m1_addr   = pend[1] ? ca[1] : $urandom;
         m1_wdata  = pend[1] ? cd[1] : $urandom;
         m1_be     = pend[1] ? cb[1] : 4'($urandom);
         cfg_rdata = src[c];
         if (c >= next_idle && (pend[0] || pend[1])) begin
            w   = (pend[0] && pend[1]) ? ~last : pend[1];
            len = cw[w] ? plen : 1;
            t   = c;
            sum = base + ca[w][15:0];
            if (w) g1[t + 1] = 1; else g0[t + 1] = 1;
            for (int k = t + 1; k <= t + 2 + len; k++) bz[k] = 1;
            for (int k = 0; k < len; k++) begin
               if (cw[w]) begin
                  we[t + 2 + k] = 1;
                  be[t + 2 + k] = cb[w];
                  wa[t + 2 + k] = {16'h0, sum};
                  wd[t + 2 + k] = cd[w];
               end else begin
                  re[t + 2 + k] = 1;
                  ra[t + 2 + k] = {16'h0, sum};
               end
            end
            if (w) begin
               d1[t + 2 + len] = 1;
               r1[t + 2 + len] = cw[w] ? 32'h0 : src[t + 2];
            end else begin
               d0[t + 2 + len] = 1;
               r0[t + 2 + len] = cw[w] ? 32'h0 : src[t + 2];
            end
            next_idle = t + 3 + len;
            last = w;
            pend[w] = 1'b0;
         end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   initial begin
      hreset    = 1'b1;
      m0_req    = 1'b0;
      m0_wr     = 1'b0;
      m0_addr   = 32'h0;
      m0_wdata  = 32'h0;
      m0_be     = 4'h0;
      m1_req    = 1'b0;
      m1_wr     = 1'b0;
      m1_addr   = 32'h0;
      m1_wdata  = 32'h0;
      m1_be     = 4'h0;
      cfg_rdata = 32'h0;
      test_reset();
      test_single_write();
      test_single_read();
      test_tie();
      test_partial_write();
      test_reset_mid_write();
      test_random(1'b0);
      test_random(1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
